// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : demux_pkg

// File: rtl/dec_3to8.sv
// Combinational binary-to-one-hot decoder. Any code that is not a clean 0-7
// (e.g. X/Z bits in simulation) falls to the default and yields all zeros.
module dec_3to8
  import demux_pkg::*;
(
  input  sel_t               sel,
  output logic [NUM_OUT-1:0] onehot
);

  // Decode select into exactly one asserted bit.
  always_comb begin
    onehot = '0;
    case (sel)
      3'd0:    onehot = 8'b0000_0001;
      3'd1:    onehot = 8'b0000_0010;
      3'd2:    onehot = 8'b0000_0100;
      3'd3:    onehot = 8'b0000_1000;
      3'd4:    onehot = 8'b0001_0000;
      3'd5:    onehot = 8'b0010_0000;
      3'd6:    onehot = 8'b0100_0000;
      3'd7:    onehot = 8'b1000_0000;
      default: onehot = '0;
    endcase
  end

endmodule : dec_3to8

// File: rtl/demux_1to8.sv
// Registered 1-to-8 demultiplexer: din is steered to the output chosen by sel,
// every other output is forced to zero. One cycle of latency, no
// combinational input-to-output path.
module demux_1to8
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  sel_t             sel,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [WIDTH-1:0] dout4,
  output logic [WIDTH-1:0] dout5,
  output logic [WIDTH-1:0] dout6,
  output logic [WIDTH-1:0] dout7,
  output logic [WIDTH-1:0] dout8
);

  logic [NUM_OUT-1:0] onehot;
  logic [WIDTH-1:0]   dout_d [NUM_OUT];
  logic [WIDTH-1:0]   dout_q [NUM_OUT];

  dec_3to8 u_dec (
    .sel    (sel),
    .onehot (onehot)
  );

  // Gate din with each one-hot bit; unselected lanes become zero.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      dout_d[i] = din & {WIDTH{onehot[i]}};
    end
  end

  // Output registers; reset wins over routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        dout_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        dout_q[i] <= dout_d[i];
      end
    end
  end

  assign dout1 = dout_q[0];
  assign dout2 = dout_q[1];
  assign dout3 = dout_q[2];
  assign dout4 = dout_q[3];
  assign dout5 = dout_q[4];
  assign dout6 = dout_q[5];
  assign dout7 = dout_q[6];
  assign dout8 = dout_q[7];

endmodule : demux_1to8

// File: tb/tb_demux_1to8.sv
// Directed self-checking bench for demux_1to8 (WIDTH = 1).
module tb_demux_1to8;

  logic       clk;
  logic       rst;
  logic       din;
  logic [2:0] sel;
  logic       dout1, dout2, dout3, dout4, dout5, dout6, dout7, dout8;

  int checks;
  int errors;

  demux_1to8 #(
    .WIDTH (1)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .sel   (sel),
    .dout1 (dout1),
    .dout2 (dout2),
    .dout3 (dout3),
    .dout4 (dout4),
    .dout5 (dout5),
    .dout6 (dout6),
    .dout7 (dout7),
    .dout8 (dout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs packed as {dout8..dout1}, so bit N-1 is doutN.
  function automatic logic [7:0] outs();
    return {dout8, dout7, dout6, dout5, dout4, dout3, dout2, dout1};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_v;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    din = 1'b1;
    sel = 3'b101;

    // Reset held two cycles with routing inputs active.
    step();
    check("reset_c1", outs(), 8'b0000_0000);
    step();
    check("reset_c2", outs(), 8'b0000_0000);
    rst = 1'b0;
    step();
    check("post_reset_sel5", outs(), 8'b0010_0000);

    // Sweep sel 0..7, two cycles each.
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      exp_v = 8'b0000_0001 << s;
      step();
      check($sformatf("sweep_sel%0d_a", s), outs(), exp_v);
      step();
      check($sformatf("sweep_sel%0d_b", s), outs(), exp_v);
    end

    // Zero data: nothing ever goes high.
    din = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      check($sformatf("zero_din_sel%0d", s), outs(), 8'b0000_0000);
    end

    // Unknown select clears all outputs; in a 2-state simulator X collapses to
    // a real code, so the expectation follows what sel actually holds.
    din = 1'b1;
    sel = 3'bxxx;
    if ($isunknown(sel)) exp_v = 8'b0000_0000;
    else                 exp_v = 8'b0000_0001 << sel;
    step();
    check("unknown_sel", outs(), exp_v);
    sel = 3'b000;
    step();
    check("after_unknown_sel0", outs(), 8'b0000_0001);

    // Back-to-back switch between neighbours.
    sel = 3'b010;
    step();
    check("b2b_sel2", outs(), 8'b0000_0100);
    sel = 3'b011;
    step();
    check("b2b_sel3", outs(), 8'b0000_1000);

    // Reset pulse mid-stream.
    sel = 3'b111;
    step();
    check("mid_pre_rst", outs(), 8'b1000_0000);
    rst = 1'b1;
    step();
    check("mid_in_rst", outs(), 8'b0000_0000);
    rst = 1'b0;
    step();
    check("mid_post_rst", outs(), 8'b1000_0000);

    // Data change on a held select follows with one cycle latency.
    din = 1'b0;
    step();
    check("din_fall_sel7", outs(), 8'b0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux_1to8
